dec8b10b: RTL and testbench

Receive-side 8b/10b decoder for the 1G Ethernet PCS; inverse of the transmit encoder. Takes one aligned 10-bit code-group per strobe and emits a registered byte with a control flag. It tracks running disparity, flags code-group and disparity violations, and runs a simplified 1000BASE-X synchronisation state machine. It sits between the deserialiser/comma aligner and the receive PCS state machine.

---
 rtl/dec8b10b_pkg.sv | 29 ++
 rtl/dec8b10b_sync.sv | 118 +++++++++++
 rtl/dec8b10b.sv | 202 ++++++++++++++++++++
 tb/tb_dec8b10b.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dec8b10b_pkg.sv
// Shared types and constants for the 8b/10b receive decoder.
// Sync FSM build option: DEC8B10B_SYNC_EN.
package dec8b10b_pkg;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    CD   = 2'd1,
    SYNC = 2'd2
  } sync_state_e;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  function automatic logic [3:0] ones10(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dec8b10b_sync.sv
// Simplified 1000BASE-X synchronisation FSM: comma acquisition and error-count loss of sync.
module dec8b10b_sync
  import dec8b10b_pkg::*;
#(
  parameter int COMMA_CNT = 3,
  parameter int ERR_LIMIT = 4,
  parameter int GOOD_CNT  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  input  logic comma,
  input  logic code_err,
  input  logic disp_err,
  output logic sync_ok
);

  localparam logic [1:0] ST_LOS  = LOS;
  localparam logic [1:0] ST_CD   = CD;
  localparam logic [1:0] ST_SYNC = SYNC;

  localparam logic [7:0] COMMA_LIM = 8'(COMMA_CNT);
  localparam logic [7:0] ERR_LIM   = 8'(ERR_LIMIT);
  localparam logic [7:0] GOOD_LIM  = 8'(GOOD_CNT);

  logic [1:0] state_r, state_s;
  logic [7:0] comma_cnt_r, comma_cnt_s;
  logic [7:0] err_cnt_r, err_cnt_s;
  logic [7:0] good_cnt_r, good_cnt_s;
  logic       sync_ok_r;
  logic       clean_s;

  assign clean_s = !code_err && !disp_err;

  // Next-state and counter update for one accepted code-group.
  always_comb begin
    state_s     = state_r;
    comma_cnt_s = comma_cnt_r;
    err_cnt_s   = err_cnt_r;
    good_cnt_s  = good_cnt_r;
    if (strobe) begin
      case (state_r)
        ST_LOS: begin
          if (comma && clean_s) begin
            state_s     = (COMMA_LIM <= 8'd1) ? ST_SYNC : ST_CD;
            comma_cnt_s = (COMMA_LIM <= 8'd1) ? 8'd0 : 8'd1;
          end else begin
            comma_cnt_s = 8'd0;
          end
        end
        ST_CD: begin
          if (!clean_s) begin
            state_s     = ST_LOS;
            comma_cnt_s = 8'd0;
          end else if (comma) begin
            if (comma_cnt_r + 8'd1 >= COMMA_LIM) begin
              state_s     = ST_SYNC;
              comma_cnt_s = 8'd0;
            end else begin
              comma_cnt_s = comma_cnt_r + 8'd1;
            end
          end else begin
            comma_cnt_s = comma_cnt_r;
          end
        end
        ST_SYNC: begin
          if (!clean_s) begin
            good_cnt_s = 8'd0;
            if (err_cnt_r + 8'd1 >= ERR_LIM) begin
              state_s   = ST_LOS;
              err_cnt_s = 8'd0;
            end else begin
              err_cnt_s = err_cnt_r + 8'd1;
            end
          end else if (good_cnt_r + 8'd1 >= GOOD_LIM) begin
            // A full run of clean symbols forgives one error; the run restarts either way.
            good_cnt_s = 8'd0;
            if (err_cnt_r != 8'd0) begin
              err_cnt_s = err_cnt_r - 8'd1;
            end else begin
              err_cnt_s = err_cnt_r;
            end
          end else begin
            good_cnt_s = good_cnt_r + 8'd1;
          end
        end
        default: begin
          state_s     = ST_LOS;
          comma_cnt_s = 8'd0;
          err_cnt_s   = 8'd0;
          good_cnt_s  = 8'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters and the registered sync indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_LOS;
      comma_cnt_r <= 8'd0;
      err_cnt_r   <= 8'd0;
      good_cnt_r  <= 8'd0;
      sync_ok_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      comma_cnt_r <= comma_cnt_s;
      err_cnt_r   <= err_cnt_s;
      good_cnt_r  <= good_cnt_s;
      sync_ok_r   <= (state_s == ST_SYNC);
    end
  end

  assign sync_ok = sync_ok_r;

endmodule

// File: rtl/dec8b10b.sv
// Receive-side 8b/10b decoder with running-disparity tracking and error flags.
// Define DEC8B10B_SYNC_EN to build the synchronisation FSM; otherwise sync_ok is tied high.
module dec8b10b
  import dec8b10b_pkg::*;
#(
  parameter int COMMA_CNT = 3,
  parameter int ERR_LIMIT = 4,
  parameter int GOOD_CNT  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic [9:0] encoded_data,
  output logic [7:0] data,
  output logic       control,
  output logic       valid,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd,
  output logic       sync_ok
);

  if (COMMA_CNT < 1 || ERR_LIMIT < 1 || GOOD_CNT < 1) begin : g_bad_cfg
    $error("dec8b10b: COMMA_CNT, ERR_LIMIT and GOOD_CNT must all be at least 1");
  end

  // Returns {valid, EDCBA}.
  function automatic logic [5:0] dec6(input logic [5:0] c);
    logic [5:0] r;
    case (c)
      6'b100111, 6'b011000: r = {1'b1, 5'd0};
      6'b011101, 6'b100010: r = {1'b1, 5'd1};
      6'b101101, 6'b010010: r = {1'b1, 5'd2};
      6'b110001:            r = {1'b1, 5'd3};
      6'b110101, 6'b001010: r = {1'b1, 5'd4};
      6'b101001:            r = {1'b1, 5'd5};
      6'b011001:            r = {1'b1, 5'd6};
      6'b111000, 6'b000111: r = {1'b1, 5'd7};
      6'b111001, 6'b000110: r = {1'b1, 5'd8};
      6'b100101:            r = {1'b1, 5'd9};
      6'b010101:            r = {1'b1, 5'd10};
      6'b110100:            r = {1'b1, 5'd11};
      6'b001101:            r = {1'b1, 5'd12};
      6'b101100:            r = {1'b1, 5'd13};
      6'b011100:            r = {1'b1, 5'd14};
      6'b010111, 6'b101000: r = {1'b1, 5'd15};
      6'b011011, 6'b100100: r = {1'b1, 5'd16};
      6'b100011:            r = {1'b1, 5'd17};
      6'b010011:            r = {1'b1, 5'd18};
      6'b110010:            r = {1'b1, 5'd19};
      6'b001011:            r = {1'b1, 5'd20};
      6'b101010:            r = {1'b1, 5'd21};
      6'b011010:            r = {1'b1, 5'd22};
      6'b111010, 6'b000101: r = {1'b1, 5'd23};
      6'b110011, 6'b001100: r = {1'b1, 5'd24};
      6'b100110:            r = {1'b1, 5'd25};
      6'b010110:            r = {1'b1, 5'd26};
      6'b110110, 6'b001001: r = {1'b1, 5'd27};
      6'b001110:            r = {1'b1, 5'd28};
      6'b101110, 6'b010001: r = {1'b1, 5'd29};
      6'b011110, 6'b100001: r = {1'b1, 5'd30};
      6'b101011, 6'b010100: r = {1'b1, 5'd31};
      6'b001111, 6'b110000: r = {1'b1, 5'd28};
      default:              r = {1'b0, 5'd0};
    endcase
    return r;
  endfunction

  // Returns {valid, HGF}.
  function automatic logic [3:0] dec4(input logic [3:0] c);
    logic [3:0] r;
    case (c)
      4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
      4'b1001:                            r = {1'b1, 3'd1};
      4'b0101:                            r = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
      4'b1010:                            r = {1'b1, 3'd5};
      4'b0110:                            r = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
      default:                            r = {1'b0, 3'd0};
    endcase
    return r;
  endfunction

  logic [5:0] six_s;
  logic [3:0] four_s, four_lk_s;
  logic [5:0] d6_s;
  logic [3:0] d4_s;
  logic [3:0] n6_s, n4_s, n10_s;
  logic       k28_s, alt7_s, kx7_s;
  logic       pos6_s, neg6_s, pos4_s, neg4_s;
  logic       rd_mid_s, rd_nxt_s;
  logic       code_err_s, disp_err_s, control_s, comma_s;
  logic [7:0] data_s;

  logic [7:0] data_r;
  logic       control_r, valid_r, code_err_r, disp_err_r, rd_r;

  // Combinational decode, validity and disparity of the current code-group.
  always_comb begin
    six_s  = encoded_data[9:4];
    four_s = encoded_data[3:0];
    k28_s  = (six_s == 6'b001111) || (six_s == 6'b110000);
    // K28 in its RD+ form carries the complemented 4b sub-block.
    four_lk_s = (six_s == 6'b110000) ? ~four_s : four_s;
    d6_s   = dec6(six_s);
    d4_s   = dec4(four_lk_s);
    n6_s   = ones10({4'd0, six_s});
    n4_s   = ones10({6'd0, four_s});
    n10_s  = ones10(encoded_data);
    alt7_s = (four_s == 4'b0111) || (four_s == 4'b1000);
    kx7_s  = (d6_s[4:0] == 5'd23) || (d6_s[4:0] == 5'd27) ||
             (d6_s[4:0] == 5'd29) || (d6_s[4:0] == 5'd30);

    code_err_s = !d6_s[5] || !d4_s[5-2] || (n10_s < 4'd4) || (n10_s > 4'd6);
    if (code_err_s) begin
      data_s    = 8'h00;
      control_s = 1'b0;
    end else begin
      data_s    = {d4_s[2:0], d6_s[4:0]};
      control_s = k28_s || (alt7_s && kx7_s);
    end

    // Only unbalanced sub-blocks are checked against the current RD;
    // 000111/111000 and 0011/1100 just force the resulting RD.
    pos6_s = (n6_s > 4'd3);
    neg6_s = (n6_s < 4'd3);
    pos4_s = (n4_s > 4'd2);
    neg4_s = (n4_s < 4'd2);

    if (pos6_s || six_s == 6'b000111) begin
      rd_mid_s = RD_POS;
    end else if (neg6_s || six_s == 6'b111000) begin
      rd_mid_s = RD_NEG;
    end else begin
      rd_mid_s = rd_r;
    end

    if (pos4_s || four_s == 4'b0011) begin
      rd_nxt_s = RD_POS;
    end else if (neg4_s || four_s == 4'b1100) begin
      rd_nxt_s = RD_NEG;
    end else begin
      rd_nxt_s = rd_mid_s;
    end

    disp_err_s = (pos6_s && rd_r == RD_POS) || (neg6_s && rd_r == RD_NEG) ||
                 (pos4_s && rd_mid_s == RD_POS) || (neg4_s && rd_mid_s == RD_NEG);

    comma_s = (encoded_data[9:3] == COMMA_POS) || (encoded_data[9:3] == COMMA_NEG);
  end

  // Output registers; everything but valid holds while no code-group arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= 8'h00;
      control_r  <= 1'b0;
      valid_r    <= 1'b0;
      code_err_r <= 1'b0;
      disp_err_r <= 1'b0;
      rd_r       <= RD_NEG;
    end else if (valid_in) begin
      data_r     <= data_s;
      control_r  <= control_s;
      valid_r    <= 1'b1;
      code_err_r <= code_err_s;
      disp_err_r <= disp_err_s;
      rd_r       <= rd_nxt_s;
    end else begin
      valid_r    <= 1'b0;
    end
  end

  assign data     = data_r;
  assign control  = control_r;
  assign valid    = valid_r;
  assign code_err = code_err_r;
  assign disp_err = disp_err_r;
  assign rd       = rd_r;

`ifdef DEC8B10B_SYNC_EN
  dec8b10b_sync #(
    .COMMA_CNT (COMMA_CNT),
    .ERR_LIMIT (ERR_LIMIT),
    .GOOD_CNT  (GOOD_CNT)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe   (valid_in),
    .comma    (comma_s),
    .code_err (code_err_s),
    .disp_err (disp_err_s),
    .sync_ok  (sync_ok)
  );
`else
  logic unused_comma_s;
  assign unused_comma_s = comma_s;
  assign sync_ok = 1'b1;
`endif

endmodule

// File: tb/tb_dec8b10b.sv
// Directed table-driven bench for dec8b10b, plus hand sequences for sync, idle and reset.
module tb_dec8b10b;

`ifdef DEC8B10B_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       valid_in;
  logic [9:0] encoded_data;
  logic [7:0] data;
  logic       control, valid, code_err, disp_err, rd, sync_ok;

  int total;
  int bad;

  typedef struct {
    logic [9:0] cg;
    logic [7:0] data;
    logic       ctrl;
    logic       cerr;
    logic       derr;
    logic       rd;
  } vec_t;

  vec_t vecs[16];

  dec8b10b dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .encoded_data (encoded_data),
    .data         (data),
    .control      (control),
    .valid        (valid),
    .code_err     (code_err),
    .disp_err     (disp_err),
    .rd           (rd),
    .sync_ok      (sync_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [9:0] cg);
    @(negedge clk);
    valid_in     = 1'b1;
    encoded_data = cg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_in = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    #1;
  endtask

  function automatic logic exp_sync(input logic v);
    return SYNC_EN ? v : 1'b1;
  endfunction

  initial begin
    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    valid_in     = 1'b0;
    encoded_data = 10'd0;

    vecs[0]  = '{10'b1001110100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{10'b0011111010, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{10'b1100000101, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{10'b0110001011, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{10'b1010101010, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{10'b1100011001, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{10'b0001110100, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{10'b1000110111, 8'hF1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{10'b0001010111, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{10'b0010101101, 8'h84, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{10'b0000001111, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{10'b1001111110, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{10'b1100000101, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{10'b0011111000, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{10'b1100000110, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{10'b0101010101, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0};

    #12;
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_control", {31'd0, control}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_code_err", {31'd0, code_err}, 32'd0);
    chk("reset_disp_err", {31'd0, disp_err}, 32'd0);
    chk("reset_rd", {31'd0, rd}, 32'd0);
    chk("reset_sync_ok", {31'd0, sync_ok}, {31'd0, exp_sync(1'b0)});
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back stream with a continuous RD chain from RD-.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].cg);
      chk($sformatf("v%0d_data", i), {24'd0, data}, {24'd0, vecs[i].data});
      chk($sformatf("v%0d_control", i), {31'd0, control}, {31'd0, vecs[i].ctrl});
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, 32'd1);
      chk($sformatf("v%0d_code_err", i), {31'd0, code_err}, {31'd0, vecs[i].cerr});
      chk($sformatf("v%0d_disp_err", i), {31'd0, disp_err}, {31'd0, vecs[i].derr});
      chk($sformatf("v%0d_rd", i), {31'd0, rd}, {31'd0, vecs[i].rd});
    end

    // Idle cycle: valid drops, everything else holds.
    idle();
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_data", {24'd0, data}, 32'h4A);
    chk("idle_rd", {31'd0, rd}, 32'd0);

    // Sync acquisition on three alternating K28.5.
    do_reset();
    send(10'b0011111010);
    chk("acq1_sync", {31'd0, sync_ok}, {31'd0, exp_sync(1'b0)});
    send(10'b1100000101);
    chk("acq2_sync", {31'd0, sync_ok}, {31'd0, exp_sync(1'b0)});
    send(10'b0011111010);
    chk("acq3_sync", {31'd0, sync_ok}, {31'd0, exp_sync(1'b1)});
    chk("acq3_rd", {31'd0, rd}, 32'd1);
    idle();
    chk("acq_idle_sync", {31'd0, sync_ok}, {31'd0, exp_sync(1'b1)});
    chk("acq_idle_data", {24'd0, data}, 32'hBC);

    // One error, then four clean symbols forgive it.
    send(10'b0000001111);
    chk("e1_code_err", {31'd0, code_err}, 32'd1);
    chk("e1_sync", {31'd0, sync_ok}, {31'd0, exp_sync(1'b1)});
    for (int i = 0; i < 4; i++) begin
      send((i % 2 == 0) ? 10'b1100000101 : 10'b0011111010);
      chk($sformatf("good%0d_disp_err", i), {31'd0, disp_err}, 32'd0);
      chk($sformatf("good%0d_sync", i), {31'd0, sync_ok}, {31'd0, exp_sync(1'b1)});
    end

    // Four errors: sync drops with the fourth.
    for (int i = 0; i < 4; i++) begin
      send(10'b0000001111);
      chk($sformatf("loss%0d_code_err", i), {31'd0, code_err}, 32'd1);
      chk($sformatf("loss%0d_data", i), {24'd0, data}, 32'd0);
      chk($sformatf("loss%0d_sync", i), {31'd0, sync_ok}, {31'd0, exp_sync(i < 3)});
    end

    // Reset asserted while a symbol is being presented discards it.
    @(negedge clk);
    valid_in     = 1'b1;
    encoded_data = 10'b0011111010;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_control", {31'd0, control}, 32'd0);
    chk("midrst_rd", {31'd0, rd}, 32'd0);
    chk("midrst_sync", {31'd0, sync_ok}, {31'd0, exp_sync(1'b0)});
    @(negedge clk);
    valid_in = 1'b0;
    reset_n  = 1'b1;
    idle();
    chk("post_rst_valid", {31'd0, valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
